// File: rtl/score_display_if.sv
// Score display bus: score strobe in, busy plus multiplexed digit/anode drive out.
// dbg_state mirrors the converter FSM state so it can be observed from outside.
interface score_display_if;
  logic [13:0] score_in;
  logic        score_valid;
  logic        busy;
  logic [3:0]  bcd;
  logic [3:0]  an;
  logic        dbg_state;

  // Strobe handshake: score_valid is a one-cycle pulse with no ready. score_in is
  // sampled on that edge. While busy is high the value is held as pending, and a
  // later strobe replaces it.
  modport master (
    output score_in, score_valid,
    input  busy, bcd, an, dbg_state
  );

  modport slave (
    input  score_in, score_valid,
    output busy, bcd, an, dbg_state
  );
endinterface

// File: rtl/score_display_mux.sv
// Binary score to four BCD digits (sequential double-dabble), time-multiplexed onto bcd/an.
// Optional LEADING_ZERO_BLANK_EN stores zero digits above the first nonzero one as blank (4'hF).
module score_display_mux #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic            clk,
  input  logic            rst_n,
  score_display_if.slave  disp
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;
  localparam int         CW       = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] REFRESH_LAST = CW'(REFRESH_DIV - 1);

  logic [0:0]    r_state;
  logic [13:0]   r_bin;
  logic [13:0]   r_pend;
  logic          r_pend_vld;
  logic [15:0]   r_work;
  logic [3:0]    r_cnt;
  logic [15:0]   r_digits;
  logic [CW-1:0] r_refresh;
  logic [1:0]    r_idx;
  logic [3:0]    r_an;
  logic [3:0]    r_bcd;

  logic [15:0]   w_adj;
  logic [15:0]   w_work_next;
  logic [15:0]   w_commit_digits;
  logic          w_commit;
  logic [13:0]   w_score_sat;
  logic [1:0]    w_idx_next;
  logic          w_wrap;

  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

`ifdef LEADING_ZERO_BLANK_EN
  function automatic logic [15:0] blank_leading(input logic [15:0] v);
    logic z3, z2, z1;
    z3 = (v[15:12] == 4'd0);
    z2 = z3 && (v[11:8] == 4'd0);
    z1 = z2 && (v[7:4] == 4'd0);
    return {z3 ? 4'hF : v[15:12], z2 ? 4'hF : v[11:8], z1 ? 4'hF : v[7:4], v[3:0]};
  endfunction
`endif

  always_comb begin
    w_score_sat = (disp.score_in > 14'd9999) ? 14'd9999 : disp.score_in;
    w_adj       = {add3(r_work[15:12]), add3(r_work[11:8]),
                   add3(r_work[7:4]),   add3(r_work[3:0])};
    w_work_next = {w_adj[14:0], r_bin[13]};
    w_commit    = (r_state == ST_SHIFT) && (r_cnt == 4'd1);
`ifdef LEADING_ZERO_BLANK_EN
    w_commit_digits = blank_leading(w_work_next);
`else
    w_commit_digits = w_work_next;
`endif
  end

  // A strobe landing on the commit edge is started directly, which is the same as
  // parking it in pending and restarting from there.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_bin      <= '0;
      r_pend     <= '0;
      r_pend_vld <= 1'b0;
      r_work     <= '0;
      r_cnt      <= '0;
      r_digits   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (disp.score_valid) begin
            r_bin   <= w_score_sat;
            r_work  <= '0;
            r_cnt   <= 4'd14;
            r_state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          r_work <= w_work_next;
          r_bin  <= {r_bin[12:0], 1'b0};
          r_cnt  <= r_cnt - 4'd1;
          if (disp.score_valid && !w_commit) begin
            r_pend     <= w_score_sat;
            r_pend_vld <= 1'b1;
          end
          if (w_commit) begin
            r_digits <= w_commit_digits;
            if (disp.score_valid || r_pend_vld) begin
              r_bin      <= disp.score_valid ? w_score_sat : r_pend;
              r_pend_vld <= 1'b0;
              r_work     <= '0;
              r_cnt      <= 4'd14;
            end else begin
              r_state <= ST_IDLE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    w_wrap     = (r_refresh == REFRESH_LAST);
    w_idx_next = r_idx + 2'd1;
  end

  // Display registers only move on the wrap edge, so a mid-slot commit waits for the next slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_refresh <= '0;
      r_idx     <= '0;
      r_an      <= 4'b1111;
      r_bcd     <= 4'hF;
    end else if (w_wrap) begin
      r_refresh <= '0;
      r_idx     <= w_idx_next;
      r_an      <= ~(4'b0001 << w_idx_next);
      r_bcd     <= r_digits[{w_idx_next, 2'b00} +: 4];
    end else begin
      r_refresh <= r_refresh + 1'b1;
    end
  end

  assign disp.busy      = (r_state == ST_SHIFT);
  assign disp.bcd       = r_bcd;
  assign disp.an        = r_an;
  assign disp.dbg_state = r_state;

endmodule

// File: tb/tb_score_display_mux.sv
// Self-checking bench for score_display_mux with REFRESH_DIV=4; honours LEADING_ZERO_BLANK_EN.
`timescale 1ns/1ps
module tb_score_display_mux;

  localparam int RD = 4;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  logic [3:0] exp_q[$];
  bit   mon_en;
  bit   seen7;

  score_display_if dif();

  score_display_mux #(.REFRESH_DIV(RD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .disp  (dif)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (mon_en && dif.bcd == 4'd7) seen7 = 1'b1;

  // reference model: decimal digits from arithmetic, units in [3:0]
  function automatic logic [15:0] model(input int v);
    int s;
    logic [3:0] d0, d1, d2, d3;
    s  = (v > 9999) ? 9999 : v;
    d0 = 4'(s % 10);
    d1 = 4'((s / 10) % 10);
    d2 = 4'((s / 100) % 10);
    d3 = 4'(s / 1000);
`ifdef LEADING_ZERO_BLANK_EN
    if (s < 1000) d3 = 4'hF;
    if (s < 100)  d2 = 4'hF;
    if (s < 10)   d1 = 4'hF;
`endif
    return {d3, d2, d1, d0};
  endfunction

  task automatic exp_push(input logic [15:0] m);
    exp_q.push_back(m[3:0]);
    exp_q.push_back(m[7:4]);
    exp_q.push_back(m[11:8]);
    exp_q.push_back(m[15:12]);
  endtask

  // driver: one-cycle strobe; returns at the negedge after the sampling edge
  task automatic strobe(input logic [13:0] v);
    dif.score_in    = v;
    dif.score_valid = 1'b1;
    @(negedge clk);
    dif.score_valid = 1'b0;
  endtask

  task automatic busy_len(input string name, input int want);
    int n;
    n = 0;
    while (dif.busy === 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
    total++;
    if (n !== want) begin
      bad++;
      $display("FAIL %s busy_cycles actual=%0d required=%0d", name, n, want);
    end
  endtask

  // scoreboard consumer: one full frame starting at the units slot
  task automatic check_frame(input string name);
    int t;
    logic [3:0] e;
    logic [3:0] ea;
    t = 0;
    while (dif.an === 4'b1110 && t < 64) begin @(negedge clk); t++; end
    while (dif.an !== 4'b1110 && t < 64) begin @(negedge clk); t++; end
    if (t >= 64) begin
      total++;
      bad++;
      $display("FAIL %s frame_sync actual_an=%b required_an=1110", name, dif.an);
      repeat (4) if (exp_q.size() > 0) void'(exp_q.pop_front());
      return;
    end
    for (int k = 0; k < 4; k++) begin
      e  = (exp_q.size() > 0) ? exp_q.pop_front() : 4'hx;
      ea = ~(4'b0001 << k);
      total++;
      if (dif.an !== ea) begin
        bad++;
        $display("FAIL %s an_slot%0d actual=%b required=%b", name, k, dif.an, ea);
      end
      total++;
      if (dif.bcd !== e) begin
        bad++;
        $display("FAIL %s bcd_slot%0d actual=%h required=%h", name, k, dif.bcd, e);
      end
      repeat (RD) @(negedge clk);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    if (dif.an !== 4'b1111) begin bad++; $display("FAIL reset_an actual=%b required=1111", dif.an); end
    total++;
    if (dif.bcd !== 4'hF) begin bad++; $display("FAIL reset_bcd actual=%h required=f", dif.bcd); end
    total++;
    if (dif.busy !== 1'b0) begin bad++; $display("FAIL reset_busy actual=%b required=0", dif.busy); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (dif.an !== 4'b1111) begin bad++; $display("FAIL reset_an_early actual=%b required=1111", dif.an); end
    @(negedge clk);
    total++;
    if (dif.an !== 4'b1101) begin bad++; $display("FAIL reset_first_an actual=%b required=1101", dif.an); end
    total++;
    if (dif.bcd !== 4'd0) begin bad++; $display("FAIL reset_first_bcd actual=%h required=0", dif.bcd); end
  endtask

  task automatic test_basic();
    exp_push(model(1234));
    strobe(14'd1234);
    busy_len("basic", 14);
    check_frame("basic");
  endtask

  task automatic test_saturation();
    exp_push(model(16383));
    strobe(14'd16383);
    busy_len("saturation", 14);
    check_frame("saturation");
  endtask

  task automatic test_pending();
    int n;
    int c;
    seen7  = 1'b0;
    mon_en = 1'b1;
    exp_push(model(88));
    strobe(14'd5);
    n = 0;
    c = 0;
    while (dif.busy === 1'b1 && c < 200) begin
      n++;
      dif.score_valid = (c == 3) || (c == 6);
      dif.score_in    = (c == 3) ? 14'd77 : 14'd88;
      c++;
      @(negedge clk);
    end
    dif.score_valid = 1'b0;
    total++;
    if (n !== 28) begin bad++; $display("FAIL pending busy_cycles actual=%0d required=28", n); end
    check_frame("pending");
    mon_en = 1'b0;
    total++;
    if (seen7 !== 1'b0) begin bad++; $display("FAIL pending_no77 actual=%b required=0", seen7); end
  endtask

  task automatic test_blank();
    exp_push(model(42));
    strobe(14'd42);
    busy_len("blank42", 14);
    check_frame("blank42");
    exp_push(model(0));
    strobe(14'd0);
    busy_len("blank0", 14);
    check_frame("blank0");
  endtask

  task automatic test_reset_mid();
    strobe(14'd9999);
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    if (dif.busy !== 1'b0) begin bad++; $display("FAIL midreset_busy actual=%b required=0", dif.busy); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    total++;
    if (dif.busy !== 1'b0) begin bad++; $display("FAIL midreset_busy_after actual=%b required=0", dif.busy); end
    exp_push(16'h0000);
    check_frame("midreset");
  endtask

  initial begin
    total           = 0;
    bad             = 0;
    mon_en          = 1'b0;
    seen7           = 1'b0;
    rst_n           = 1'b0;
    dif.score_in    = '0;
    dif.score_valid = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    test_basic();
    test_saturation();
    test_pending();
    test_blank();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
